// File: rtl/dev_reshuffler_serializer.sv
// dev_reshuffler_serializer: takes one SpatPar x SpatPar element tile over a
// valid/ready handshake and emits it as SpatPar beats of DataWidth bits, one
// tile row per beat, with an optional transpose applied when the tile is captured.
// Latency: a tile accepted at clock edge t drives beat 0 in cycle t+1. A full
// tile takes SpatPar beats at 1 beat/cycle, with no bubble between back-to-back tiles.
// Backpressure: z_ready_i low freezes the beat counter and the output beat.
// a_ready_o is high only when idle, or when the last beat of the current tile
// transfers in this same cycle.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   a_i                 input tile; element (i,j) at [(i*SpatPar+j)*Elems +: Elems]
//   a_valid_i/a_ready_o input tile handshake
//   csr_en_transpose_i  transpose enable, sampled only when a tile is accepted
//   z_o                 output beat (one tile row)
//   z_valid_o/z_ready_i output beat handshake
//   z_last_o            current beat is the final row of the tile
//   busy_o              a tile is held and not yet fully emitted
//
// Build option: define DEV_RESHUFFLER_SERIALIZER_TRANSPOSE_EN to build the
// transpose path. Without it, csr_en_transpose_i is ignored and tiles are
// always stored untransposed.
// DataWidth must be a multiple of SpatPar.

module dev_reshuffler_serializer #(
    parameter int SpatPar   = 8,
    parameter int DataWidth = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [SpatPar*DataWidth-1:0] a_i,
    input  logic                         a_valid_i,
    output logic                         a_ready_o,
    input  logic                         csr_en_transpose_i,
    output logic [DataWidth-1:0]         z_o,
    output logic                         z_valid_o,
    input  logic                         z_ready_i,
    output logic                         z_last_o,
    output logic                         busy_o
);
    localparam int Elems = DataWidth / SpatPar;
    localparam int CntW  = (SpatPar > 1) ? $clog2(SpatPar) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(SpatPar - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                       state_q, state_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [SpatPar*DataWidth-1:0] tile_q, tile_d;
    logic [SpatPar*DataWidth-1:0] tile_in;
    logic [DataWidth-1:0]         row;
    logic                         is_send;
    logic                         is_last;
    logic                         accept;

    // Tile as it will be stored: optionally transposed at capture time, so
    // the emit side always reads plain rows.
`ifdef DEV_RESHUFFLER_SERIALIZER_TRANSPOSE_EN
    always_comb begin
        tile_in = a_i;
        if (csr_en_transpose_i) begin
            for (int i = 0; i < SpatPar; i++) begin
                for (int j = 0; j < SpatPar; j++) begin
                    tile_in[(i*SpatPar+j)*Elems +: Elems] = a_i[(j*SpatPar+i)*Elems +: Elems];
                end
            end
        end
    end
`else
    assign tile_in = a_i;
    logic unused_csr_en_transpose;
    assign unused_csr_en_transpose = csr_en_transpose_i;
`endif

    // Row t[beat][*] occupies one contiguous DataWidth slice of the tile.
    always_comb begin
        row = '0;
        for (int r = 0; r < SpatPar; r++) begin
            if (cnt_q == CntW'(r)) begin
                row = tile_q[r*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tile_d  = tile_q;

        // Outputs are masked while reset is asserted, so an aborted tile
        // never shows another beat.
        is_send = (state_q == SEND) && !rst_i;
        is_last = is_send && (cnt_q == LastBeat);

        // Combinational z_ready_i -> a_ready_o path: the next tile loads in the
        // same cycle as the last beat, so consecutive tiles have no bubble.
        a_ready_o = !rst_i && ((state_q == IDLE) || (is_last && z_ready_i));
        accept    = a_valid_i && a_ready_o;

        z_valid_o = is_send;
        z_last_o  = is_last;
        busy_o    = is_send;
        z_o       = is_send ? row : '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    tile_d  = tile_in;
                end
            end
            SEND: begin
                if (z_ready_i) begin
                    if (cnt_q == LastBeat) begin
                        cnt_d = '0;
                        if (accept) begin
                            tile_d = tile_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tile_q  <= tile_d;
        end
    end

endmodule

// File: doc/dev_reshuffler_serializer.md
# dev_reshuffler_serializer

Write-side counterpart of the data reshuffler. It accepts one wide tile of SpatPar×SpatPar elements over a valid-ready handshake, optionally transposes it, and emits it as SpatPar narrow beats of DataWidth bits, one row per beat. It sits between an accelerator's wide result port and a narrow streamer/TCDM write port.

## Interface
- SpatPar, 8, number of rows/columns in a tile; also the number of output beats per tile
- DataWidth, 64, bits per output beat (one tile row)
- Elems, DataWidth/SpatPar, bits per element; DataWidth % SpatPar must be 0
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- a_i  in  SpatPar*DataWidth  input tile; element (i,j) at bits [(i*SpatPar+j)*Elems +: Elems]
- a_valid_i  in  1  input tile valid
- a_ready_o  out  1  serializer can accept a tile this cycle
- csr_en_transpose_i  in  1  transpose enable, sampled only on tile accept
- z_o  out  DataWidth  current output beat (one tile row)
- z_valid_o  out  1  output beat valid
- z_ready_i  in  1  downstream accepts beat
- z_last_o  out  1  current beat is the final row of the tile
- busy_o  out  1  a tile is held and not fully emitted

## Operation
- States: IDLE (no tile held), SEND (tile held, emitting rows).
- Tile accept = a_valid_i && a_ready_o. On accept, register tile t[i][j] = csr_en_transpose_i ? a[j][i] : a[i][j]; clear beat counter to 0; go to SEND.
- Beat counter: $clog2(SpatPar) bits (min 1), counts 0..SpatPar-1.
- In SEND, z_o[j*Elems +: Elems] = t[beat][j] for j in 0..SpatPar-1; z_valid_o=1; z_last_o = (beat == SpatPar-1).
- Beat transfer = z_valid_o && z_ready_i; it increments the counter.
- Transfer on the last beat: if a tile is accepted in the same cycle, load the new tile, counter to 0, stay in SEND; otherwise go to IDLE.
- a_ready_o = (state==IDLE) || (state==SEND && z_last_o && z_ready_i). This is a combinational path from z_ready_i to a_ready_o by design; it gives back-to-back tiles with no bubble.
- a_valid_i while not ready: the tile is not taken and the upstream must hold it. Held tile and transpose setting are unaffected by later changes to a_i or csr_en_transpose_i.
- z_valid_o is never deasserted before its transfer. z_o is stable while z_valid_o && !z_ready_i.
- IDLE: z_valid_o=0, z_last_o=0, busy_o=0, z_o=0.
- busy_o = (state==SEND).

## Timing
- Reset (rst_i high at a clock edge): state=IDLE, counter=0, tile register=0. During and after reset: z_valid_o=0, z_last_o=0, busy_o=0, z_o=0. a_ready_o is forced 0 while rst_i is high and is 1 in the first cycle after release.
- Reset mid-tile aborts the tile. No remaining beats are emitted.
- Latency: tile accepted at edge t → beat 0 valid in cycle t+1.
- Full tile with z_ready_i held high takes exactly SpatPar cycles. Sustained throughput is 1 beat/cycle, including across tile boundaries.
- Stall: z_ready_i low holds the counter, z_o, z_valid_o and z_last_o unchanged.

## Configuration
- DEV_RESHUFFLER_SERIALIZER_TRANSPOSE_EN defined: transpose path built as described; csr_en_transpose_i is honored.
- Not defined: the transpose mux is not built. csr_en_transpose_i is ignored and the tile is always stored untransposed (t[i][j] = a[i][j]). Ports are unchanged.

## Test plan
Benches use SpatPar=4, DataWidth=32 (Elems=8), with element (i,j) = i*4+j.
- Reset, then one tile with transpose=0 and z_ready_i=1 → beats in cycles t+1..t+4 are 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. z_last_o is high only on the 4th beat; busy_o falls after it.
- Same tile with transpose=1 (macro defined) → beats 0x0C080400, 0x0D090501, 0x0E0A0602, 0x0F0B0703. With the macro undefined → the untransposed sequence above.
- Backpressure: z_ready_i low for 3 cycles during beat 1 → z_o holds 0x07060504 with valid high for the whole stall; no beat is lost or duplicated; a_ready_o stays 0 throughout.
- Back-to-back: two tiles presented continuously with z_ready_i=1 → 8 consecutive valid beats with no bubble. a_ready_o is high in the last-beat cycle of tile 1; the second tile's transpose bit, changed only at its accept, applies only to tile 2.
- Reset asserted after beat 1 of a tile → the next cycle shows z_valid_o=0 and busy_o=0; after release a new tile starts at beat 0.
- Input changed while held: a_i and csr_en_transpose_i toggled randomly during SEND → output rows always match the tile captured at accept.
